exp_combine: RTL
================

Name: exp_combine

Overview:
- Downstream neighbour of the power-of-two shifter in the softmax exp path.
- Pairs each 2^k FP32 word from the shifter with the matching 2^f FP32 word from the fractional-exponent approximator.
- Forms exp = 2^k * 2^f by exponent addition, then saturates or flushes the result.
- Feeds the FP32 exp value to the accumulator/normaliser through a ready/valid output; the two input streams arrive at independent latencies and are aligned by internal FIFOs.

Parameters:
- BITWIDTH, 32, data word width; FP32 only, other values unsupported.
- DEPTH, 4, entries per alignment FIFO; power of two, >= 2.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Pow2_vld  input  1  Pow2_data valid; driven by shifter DataOut_vld; no backpressure.
- Pow2_data  input  BITWIDTH  FP32 2^k; mantissa bits ignored.
- Frac_vld  input  1  Frac_data valid; no backpressure.
- Frac_data  input  BITWIDTH  FP32 2^f, nominally in [1,2).
- Out_vld  output  1  Out_data valid.
- Out_rdy  input  1  downstream accepts when Out_vld && Out_rdy.
- Out_data  output  BITWIDTH  FP32 product.
- Err_ovf  output  1  sticky; a push occurred into a full FIFO.

Behaviour:
- Reset: synchronous, active-high (Reset, Clock). Out_vld=0, Out_data=0, Err_ovf=0; both FIFOs emptied; pipeline valids cleared. Reset mid-operation discards all in-flight data.
- Push rules:
  - Pow2_vld=1 pushes Pow2_data into FIFO P; Frac_vld=1 pushes Frac_data into FIFO F.
  - Push into a full FIFO: word dropped, Err_ovf set until Reset.
  - Simultaneous push and pop on a full FIFO is allowed and is not an overflow.
- Pairing:
  - Pop both FIFOs in the same cycle when both are non-empty and stage 1 can advance.
  - Strict FIFO order: the n-th Pow2 word pairs with the n-th Frac word.
- Pipeline, 2 stages:
  - S1 registers sign = sP^sF and esum = EP + EF - 127 (10-bit signed), plus mantissa mF and flags zP=(EP==0), iP=(EP==255).
  - S2 registers Out_data.
  - Stage n advances when stage n+1 is empty or advancing. S2 advances when !Out_vld || Out_rdy.
  - Latency from pop to Out_vld: 2 cycles. Throughput: 1 result/cycle with Out_rdy=1.
- Output held stable while Out_vld && !Out_rdy.
- Result rules, in priority order:
  - zP or EF==0 -> {sign, 31'h0}.
  - iP, EF==255, or esum>=255 -> {sign, 31'h7F7FFFFF} (saturate to max finite; never Inf/NaN).
  - esum<=0 -> {sign, 31'h0} (flush to zero).
  - else -> {sign, esum[7:0], mF}.
- Input word pushed in cycle t with the partner already present: popped in cycle t+1, Out_vld in cycle t+3.

Optional Feature:
- Macro: EXP_COMBINE_STATS_EN.
- Defined: adds outputs Sat_cnt[15:0] and Flush_cnt[15:0].
  - Sat_cnt increments on each accepted output taking the saturate rule.
  - Flush_cnt increments on each accepted output taking the flush rule; the zero-operand rule is not counted.
  - Both saturate at 16'hFFFF and clear on Reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package softmax_pkg:
  - FP32 field constants: EXP_W=8, MAN_W=23, BIAS=127.
  - FP32_MAX_FINITE=31'h7F7FFFFF.
  - Packed FP32 struct typedef (sign/exp/man).
- Sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice for FIFO P and FIFO F. It provides full/empty, push/pop and an overflow pulse; the sticky flag lives in exp_combine.

Test Plan:
- Basic product: Pow2 0x41000000 (k=3) and Frac 0x3FC00000 (1.5) in the same cycle, Out_rdy=1 -> Out_data 0x41400000 (12.0) 3 cycles later.
- Skewed arrival: Frac 0x3F800000, 0x3FC00000, 0x3FE00000 in cycles 0-2; Pow2 0x3F800000, 0x40000000, 0x40800000 in cycles 3-5 -> outputs 0x3F800000, 0x40400000, 0x40E00000 in order.
- Flush/zero:
  - Pow2 0x00800000 with Frac 0x3F000000 -> 0x00000000.
  - Pow2 0x00000000 with Frac 0x3FC00000 -> 0x00000000.
- Saturation: Pow2 0x7F800000 with Frac 0x3F800000 -> 0x7F7FFFFF; Sat_cnt=1 when EXP_COMBINE_STATS_EN is defined.
- Backpressure: 3 valid pairs, Out_rdy low for 5 cycles -> Out_data held constant, no loss; all 3 results delivered in order after Out_rdy rises.
- Overflow and reset: DEPTH=4, 5 Pow2 pushes with no Frac -> Err_ovf=1 on the 5th, 5th word dropped. Reset asserted mid-stream -> Out_vld=0, Err_ovf=0, next pair processed normally.

Source files
------------

// File: rtl/softmax_pkg.sv
// FP32 field layout and constants shared by the softmax exp path.
// Used by exp_combine; no logic of its own.
package softmax_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam logic [30:0] FP32_MAX_FINITE = 31'h7F7FFFFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;
endpackage

// File: rtl/exp_combine_if.sv
// Stream bundle between shifter/approximator, exp_combine and the accumulator.
// slave = combiner view, master = producer/consumer view.
interface exp_combine_if #(parameter int BITWIDTH = 32);
    logic                Pow2_vld;
    logic [BITWIDTH-1:0] Pow2_data;
    logic                Frac_vld;
    logic [BITWIDTH-1:0] Frac_data;
    logic                Out_vld;
    logic                Out_rdy;
    logic [BITWIDTH-1:0] Out_data;
    logic                Err_ovf;

    modport slave (
        input  Pow2_vld, Pow2_data, Frac_vld, Frac_data, Out_rdy,
        output Out_vld, Out_data, Err_ovf
    );
    modport master (
        output Pow2_vld, Pow2_data, Frac_vld, Frac_data, Out_rdy,
        input  Out_vld, Out_data, Err_ovf
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read port; push into a full FIFO is dropped
// and flagged on ovf_o unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dat_o   = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign ovf_o   = push_i && full_o && !do_pop;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= dat_i;
    end
endmodule

// File: rtl/exp_combine.sv
// Pairs 2^k and 2^f FP32 streams through alignment FIFOs and forms 2^k*2^f by
// exponent addition with saturate/flush; 2-stage pipeline, stalls on Out_rdy.
// Optional EXP_COMBINE_STATS_EN adds saturate/flush event counters.
module exp_combine
    import softmax_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    exp_combine_if.slave bus
`ifdef EXP_COMBINE_STATS_EN
    ,
    output logic [15:0]  Sat_cnt,
    output logic [15:0]  Flush_cnt
`endif
);
    logic [BITWIDTH-1:0] p_raw, f_raw;
    fp32_t               p_dat, f_dat;
    logic                p_empty, p_full, p_ovf;
    logic                f_empty, f_full, f_ovf;
    logic                pop, s1_adv, s2_adv;

    logic                s1_vld_q, s1_sign_q, s1_zero_q, s1_inf_q;
    logic signed [9:0]   s1_esum_q;
    logic [MAN_W-1:0]    s1_man_q;
    logic                out_vld_q, err_q;
    logic [BITWIDTH-1:0] out_dat_q, res_d;

    sync_fifo #(.WIDTH(BITWIDTH), .DEPTH(DEPTH)) u_fifo_p (
        .Clock(Clock), .Reset(Reset), .push_i(bus.Pow2_vld), .dat_i(bus.Pow2_data),
        .pop_i(pop), .dat_o(p_raw), .full_o(p_full), .empty_o(p_empty), .ovf_o(p_ovf)
    );
    sync_fifo #(.WIDTH(BITWIDTH), .DEPTH(DEPTH)) u_fifo_f (
        .Clock(Clock), .Reset(Reset), .push_i(bus.Frac_vld), .dat_i(bus.Frac_data),
        .pop_i(pop), .dat_o(f_raw), .full_o(f_full), .empty_o(f_empty), .ovf_o(f_ovf)
    );

    assign p_dat  = fp32_t'(p_raw);
    assign f_dat  = fp32_t'(f_raw);
    assign s2_adv = !out_vld_q || bus.Out_rdy;
    assign s1_adv = !s1_vld_q || s2_adv;
    assign pop    = !p_empty && !f_empty && s1_adv;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_vld_q <= 1'b0;
        end else if (s1_adv) begin
            s1_vld_q <= pop;
        end
        if (pop) begin
            s1_sign_q <= p_dat.sign ^ f_dat.sign;
            // 10-bit signed holds the full range -127..383 of EP+EF-BIAS
            s1_esum_q <= $signed({2'b00, p_dat.exp} + {2'b00, f_dat.exp} - 10'(BIAS));
            s1_man_q  <= f_dat.man;
            s1_zero_q <= (p_dat.exp == '0) || (f_dat.exp == '0);
            s1_inf_q  <= (p_dat.exp == '1) || (f_dat.exp == '1);
        end
    end

    always_comb begin
        res_d = '0;
        if (s1_zero_q)
            res_d = {s1_sign_q, 31'h0};
        else if (s1_inf_q || s1_esum_q >= 10'sd255)
            res_d = {s1_sign_q, FP32_MAX_FINITE};
        else if (s1_esum_q <= 10'sd0)
            res_d = {s1_sign_q, 31'h0};
        else
            res_d = {s1_sign_q, s1_esum_q[7:0], s1_man_q};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) out_dat_q <= res_d;
            end
            err_q <= err_q | p_ovf | f_ovf;
        end
    end

    assign bus.Out_vld  = out_vld_q;
    assign bus.Out_data = out_dat_q;
    assign bus.Err_ovf  = err_q;

`ifdef EXP_COMBINE_STATS_EN
    logic        sat_tag_q, flush_tag_q, accept;
    logic [15:0] sat_cnt_q, flush_cnt_q;

    assign accept = out_vld_q && bus.Out_rdy;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sat_tag_q   <= 1'b0;
            flush_tag_q <= 1'b0;
            sat_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (s2_adv && s1_vld_q) begin
                sat_tag_q   <= !s1_zero_q && (s1_inf_q || s1_esum_q >= 10'sd255);
                flush_tag_q <= !s1_zero_q && !s1_inf_q && (s1_esum_q <= 10'sd0);
            end
            if (accept && sat_tag_q && sat_cnt_q != 16'hFFFF)
                sat_cnt_q <= sat_cnt_q + 16'd1;
            if (accept && flush_tag_q && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign Sat_cnt   = sat_cnt_q;
    assign Flush_cnt = flush_cnt_q;
`endif
endmodule
